ctrl_burst_data: RTL and testbench
==================================

# ctrl_burst_data

Downstream neighbour of the CAS timing stage. It takes each issued CAS command (`cas_rdy` pulse plus `cas_req`), waits the read latency (AL+CL) or write latency (AL+CWL), then frames the data burst on the DQ/DQS enables and reports completion with `rw_done`. `rw_done` is the signal the CAS stage waits on before a read-to-write turnaround. Up to 4 issued-but-unfinished CAS commands are queued, so back-to-back CAS at tCCD spacing produces seamless bursts.

## Interface
Parameters:
- `QDEPTH`, 4: pending-burst queue depth, power of 2.
- `TSW`, 8: timestamp width in bits.

Ports:
- `CK_t` in 1: controller clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `cas_rdy` in 1: one-cycle pulse; CAS command issued this cycle.
- `cas_req` in 3: request type (ddr_pkg encodings RD_R, RDA_R, WR_R, WRA_R); valid when `cas_rdy`=1.
- `CL`, `CWL`, `AL` in 5 each: programmed latencies; sampled at `cas_rdy`.
- `BL` in 5: burst length; 4 = BC4, any other value is treated as 8; sampled at `cas_rdy`.
- `rd_data_en` out 1: read capture window.
- `wr_data_en` out 1: DQ/DM drive window.
- `dqs_en` out 1: equals `rd_data_en | wr_data_en`.
- `beat_idx` out 2: clock index within the current burst (0..BL/2-1).
- `rw_done` out 1: pulse on the last clock of each burst.
- `precharge_req` out 1: pulse coincident with `rw_done` for RDA_R/WRA_R only.
- `busy` out 1: queue non-empty or burst active.
- `q_full` out 1: queue holds QDEPTH entries.
- `overflow_err` out 1: sticky; a CAS was dropped.
- `late_err` out 1: sticky; a burst started after its due cycle.

## Operation
- Free-running `cyc` counter, TSW bits, wraps modulo 2^TSW; cleared by reset.
- On `cas_rdy`, push an entry {is_wr, ap, len, due}:
  - is_wr = request is WR_R or WRA_R.
  - ap = request is RDA_R or WRA_R.
  - len = 2 if BL==4, else 4.
  - due = cyc + (is_wr ? AL+CWL : AL+CL), computed 6-bit, added modulo 2^TSW.
- If `cas_req` is not a valid encoding: no push; no error is flagged.
- Queue is a FIFO. Push with `q_full`=1 and no pop in the same cycle: entry dropped, `overflow_err` set. Push and pop in the same cycle are both allowed when full.
- Head is due when (cyc - due) mod 2^TSW < 2^(TSW-1), i.e. due now or already passed.
- FSM states and transitions:
  - D_IDLE: queue empty; all enables 0. A push moves to D_WAIT.
  - D_WAIT: when the head is due, pop it and enter D_BURST with `beat_idx`=0. Set `late_err` if cyc != due.
  - D_BURST: drives `rd_data_en` or `wr_data_en` per is_wr. `beat_idx` increments each clock. On `beat_idx`==len-1, pulse `rw_done` (plus `precharge_req` if ap). Next state:
    - head present and due next cycle: pop at the last beat, stay in D_BURST, `beat_idx`=0 (seamless).
    - queue non-empty otherwise: D_WAIT.
    - queue empty: D_IDLE.
- A head that becomes due while a burst is still running is never launched early. It launches after the current burst ends and sets `late_err`.
- Type changes between consecutive bursts need no special handling; turnaround gaps are the CAS stage's job.

## Timing
- CAS accepted in cycle T (`cas_rdy`=1 at edge T).
- Read: `rd_data_en`=1 in cycles T+AL+CL .. T+AL+CL+len-1; `rw_done` in cycle T+AL+CL+len-1.
- Write: same windows with AL+CWL.
- Latency value 0 is clamped to 1: a burst never starts in the same cycle as its CAS.
- All outputs are registered.
- Reset values: every output 0, queue empty, state D_IDLE, `cyc`=0, both sticky errors cleared.
- Reset mid-burst: the queue is flushed and enables drop at the next edge. No `rw_done` is emitted for aborted bursts.
- Sticky errors clear only on reset.

## Test plan
- Single read: AL=0, CL=11, BL=8, RD_R at T=10 -> `rd_data_en` cycles 21..24, `beat_idx` 0..3, `rw_done` at 24, no `precharge_req`.
- Write with auto-precharge: AL=2, CWL=9, BC4, WRA_R at T=5 -> `wr_data_en` 16..17, `rw_done` and `precharge_req` at 17.
- Seamless: CL=11, two RD_R 4 cycles apart at T=0 and T=4 -> `rd_data_en` continuous 11..18, `rw_done` at 14 and 18, `late_err`=0.
- Overflow: CL=20, five RD_R at T=0..4 -> 5th dropped, `overflow_err`=1, exactly 4 `rw_done` pulses.
- Collision: CL=11 RD_R at T=0, BL=8; then WR_R at T=1 with CWL=9 (due 10) -> write runs 15..18, `late_err`=1.
- Wrap and reset: start RD_R at `cyc`=250 with CL=11 -> burst at `cyc` 5..8. Assert `reset` at `cyc`=6 -> all outputs 0 next edge, no `rw_done`.

Source files
------------

// File: rtl/ctrl_burst_data.sv
// ctrl_burst_data: queues issued CAS commands, waits AL+CL / AL+CWL, then frames the DQ/DQS burst and flags completion.
module ctrl_burst_data #(
   parameter int QDEPTH = 4,
   parameter int TSW    = 8
) (
   input  logic       CK_t,
   input  logic       reset,
   input  logic       cas_rdy,
   input  logic [2:0] cas_req,
   input  logic [4:0] CL,
   input  logic [4:0] CWL,
   input  logic [4:0] AL,
   input  logic [4:0] BL,
   output logic       rd_data_en,
   output logic       wr_data_en,
   output logic       dqs_en,
   output logic [1:0] beat_idx,
   output logic       rw_done,
   output logic       precharge_req,
   output logic       busy,
   output logic       q_full,
   output logic       overflow_err,
   output logic       late_err
);
   localparam logic [2:0] RD_R  = 3'd1;
   localparam logic [2:0] RDA_R = 3'd2;
   localparam logic [2:0] WR_R  = 3'd3;
   localparam logic [2:0] WRA_R = 3'd4;
   localparam logic [1:0] D_IDLE  = 2'd0;
   localparam logic [1:0] D_WAIT  = 2'd1;
   localparam logic [1:0] D_BURST = 2'd2;
   localparam int AW = $clog2(QDEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);
   localparam logic [TSW-1:0] HALF = {1'b1, {(TSW-1){1'b0}}};

   typedef struct packed {
      logic           is_wr;
      logic           ap;
      logic           bc4;
      logic [TSW-1:0] due;
   } ent_t;

   ent_t q [QDEPTH];
   ent_t ent_in, head;
   logic [AW-1:0] rp, wp;
   logic [AW:0] cnt, cnt_n;
   logic [TSW-1:0] cyc, nxt;
   logic [1:0] state, state_n, beat_n;
   logic cur_wr, cur_ap, cur_bc4, wr_n, ap_n, bc4_n;
   logic valid_req, in_wr, in_ap, empty, head_due, in_burst, last;
   logic launch, pop, bypass, push, drop, burst_n, done_n;
   logic [5:0] lat6, lat;

   // All decisions are made for the cycle being entered (nxt), so every output can be registered.
   always_comb begin
      valid_req = cas_rdy && (cas_req inside {RD_R, RDA_R, WR_R, WRA_R});
      in_wr     = cas_req == WR_R || cas_req == WRA_R;
      in_ap     = cas_req == RDA_R || cas_req == WRA_R;
      lat6      = in_wr ? {1'b0, AL} + {1'b0, CWL} : {1'b0, AL} + {1'b0, CL};
      lat       = lat6 == 6'd0 ? 6'd1 : lat6;
      nxt       = cyc + TSW'(1);
      ent_in    = {in_wr, in_ap, BL == 5'd4, cyc + TSW'(lat)};
      empty     = cnt == '0;
      // An empty queue lets a fresh CAS launch directly, which latency 1 requires.
      head      = empty ? ent_in : q[rp];
      head_due  = (!empty || valid_req) && ((nxt - head.due) < HALF);
      in_burst  = state == D_BURST;
      last      = in_burst && beat_idx == (cur_bc4 ? 2'd1 : 2'd3);
      launch    = (!in_burst || last) && head_due;
      pop       = launch && !empty;
      bypass    = launch && empty;
      push      = valid_req && !bypass && (cnt != FULL || pop);
      drop      = valid_req && !bypass && cnt == FULL && !pop;
      cnt_n     = cnt + (AW+1)'(push) - (AW+1)'(pop);
      state_n   = (launch || (in_burst && !last)) ? D_BURST : cnt_n != '0 ? D_WAIT : D_IDLE;
      beat_n    = launch ? 2'd0 : (in_burst && !last) ? beat_idx + 2'd1 : 2'd0;
      wr_n      = launch ? head.is_wr : cur_wr;
      ap_n      = launch ? head.ap : cur_ap;
      bc4_n     = launch ? head.bc4 : cur_bc4;
      burst_n   = state_n == D_BURST;
      done_n    = burst_n && beat_n == (bc4_n ? 2'd1 : 2'd3);
   end

   always_ff @(posedge CK_t)
      if (push) q[wp] <= ent_in;

   always_ff @(posedge CK_t) begin
      if (reset) begin
         cyc           <= '0;
         state         <= D_IDLE;
         cnt           <= '0;
         rp            <= '0;
         wp            <= '0;
         cur_wr        <= 1'b0;
         cur_ap        <= 1'b0;
         cur_bc4       <= 1'b0;
         beat_idx      <= 2'd0;
         rd_data_en    <= 1'b0;
         wr_data_en    <= 1'b0;
         dqs_en        <= 1'b0;
         rw_done       <= 1'b0;
         precharge_req <= 1'b0;
         busy          <= 1'b0;
         q_full        <= 1'b0;
         overflow_err  <= 1'b0;
         late_err      <= 1'b0;
      end else begin
         cyc           <= nxt;
         state         <= state_n;
         cnt           <= cnt_n;
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cur_wr        <= wr_n;
         cur_ap        <= ap_n;
         cur_bc4       <= bc4_n;
         beat_idx      <= beat_n;
         rd_data_en    <= burst_n && !wr_n;
         wr_data_en    <= burst_n && wr_n;
         dqs_en        <= burst_n;
         rw_done       <= done_n;
         precharge_req <= done_n && ap_n;
         busy          <= cnt_n != '0 || burst_n;
         q_full        <= cnt_n == FULL;
         if (drop) overflow_err <= 1'b1;
         if (launch && head.due != nxt) late_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ctrl_burst_data.sv
// tb_ctrl_burst_data: directed checks of burst timing, queueing, overflow, lateness, wrap and reset.
module tb_ctrl_burst_data;
   localparam logic [2:0] RD_R  = 3'd1;
   localparam logic [2:0] RDA_R = 3'd2;
   localparam logic [2:0] WR_R  = 3'd3;
   localparam logic [2:0] WRA_R = 3'd4;

   logic CK_t = 1'b0, reset = 1'b1, cas_rdy = 1'b0;
   logic [2:0] cas_req = 3'd0;
   logic [4:0] CL = 5'd0, CWL = 5'd0, AL = 5'd0, BL = 5'd8;
   logic rd_data_en, wr_data_en, dqs_en, rw_done, precharge_req, busy, q_full, overflow_err, late_err;
   logic [1:0] beat_idx;
   int checks = 0, failures = 0, t = 0, dones;
   logic inw;

   ctrl_burst_data dut (
      .CK_t(CK_t), .reset(reset), .cas_rdy(cas_rdy), .cas_req(cas_req),
      .CL(CL), .CWL(CWL), .AL(AL), .BL(BL),
      .rd_data_en(rd_data_en), .wr_data_en(wr_data_en), .dqs_en(dqs_en), .beat_idx(beat_idx),
      .rw_done(rw_done), .precharge_req(precharge_req), .busy(busy), .q_full(q_full),
      .overflow_err(overflow_err), .late_err(late_err)
   );

   always #5 CK_t = ~CK_t;

   task automatic tick;
      @(posedge CK_t);
      #1;
      t = t + 1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   task automatic chk_cyc(input string tag, input logic rd, input logic wr, input logic [1:0] b,
                          input logic done, input logic pre);
      check(tag, {9'd0, rd_data_en, wr_data_en, dqs_en, beat_idx, rw_done, precharge_req},
            {9'd0, rd, wr, rd | wr, b, done, pre});
   endtask

   task automatic chk_all_zero(input string tag);
      check(tag, {5'd0, rd_data_en, wr_data_en, dqs_en, beat_idx, rw_done, precharge_req,
                  busy, q_full, overflow_err, late_err}, 16'd0);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      t = 0;
   endtask

   task automatic idle_to(input int target);
      while (t < target) tick;
   endtask

   task automatic cas(input logic [2:0] req, input logic [4:0] al, input logic [4:0] cl,
                      input logic [4:0] cwl, input logic [4:0] bl);
      cas_rdy = 1'b1;
      cas_req = req;
      AL = al;
      CL = cl;
      CWL = cwl;
      BL = bl;
      tick;
      cas_rdy = 1'b0;
      cas_req = 3'd0;
   endtask

   initial begin
      do_reset;
      chk_all_zero("reset_state");

      // single read: 21..24
      idle_to(10);
      cas(RD_R, 5'd0, 5'd11, 5'd0, 5'd8);
      check("rd1_busy", {15'd0, busy}, 16'd1);
      while (t <= 25) begin
         inw = t >= 21 && t <= 24;
         chk_cyc("rd1", inw, 1'b0, inw ? 2'(t - 21) : 2'd0, t == 24, 1'b0);
         tick;
      end
      check("rd1_late", {15'd0, late_err}, 16'd0);
      check("rd1_idle", {15'd0, busy}, 16'd0);

      // write with auto-precharge, BC4: 16..17
      do_reset;
      idle_to(5);
      cas(WRA_R, 5'd2, 5'd0, 5'd9, 5'd4);
      while (t <= 19) begin
         inw = t >= 16 && t <= 17;
         chk_cyc("wra", 1'b0, inw, inw ? 2'(t - 16) : 2'd0, t == 17, t == 17);
         tick;
      end

      // seamless reads: 11..18 continuous
      do_reset;
      cas(RD_R, 5'd0, 5'd11, 5'd0, 5'd8);
      idle_to(4);
      cas(RD_R, 5'd0, 5'd11, 5'd0, 5'd8);
      while (t <= 20) begin
         inw = t >= 11 && t <= 18;
         chk_cyc("seamless", inw, 1'b0, inw ? 2'(t - 11) : 2'd0, t == 14 || t == 18, 1'b0);
         tick;
      end
      check("seamless_late", {15'd0, late_err}, 16'd0);

      // overflow: five reads, fifth dropped
      do_reset;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) check("ovf_full", {14'd0, q_full, overflow_err}, 16'b10);
         cas(RD_R, 5'd0, 5'd20, 5'd0, 5'd8);
      end
      check("ovf_err", {14'd0, busy, overflow_err}, 16'b11);
      dones = 0;
      while (t < 60) begin
         if (rw_done) dones++;
         tick;
      end
      check("ovf_dones", 16'(dones), 16'd4);
      check("ovf_end", {13'd0, busy, overflow_err, late_err}, 16'b011);

      // collision: write due at 10 waits behind read 11..14, runs 15..18 late
      do_reset;
      cas(RD_R, 5'd0, 5'd11, 5'd0, 5'd8);
      cas(WR_R, 5'd0, 5'd0, 5'd9, 5'd8);
      while (t <= 20) begin
         chk_cyc("collide", t >= 11 && t <= 14, t >= 15 && t <= 18,
                 (t >= 11 && t <= 18) ? 2'(t - 11) : 2'd0, t == 14 || t == 18, 1'b0);
         tick;
      end
      check("collide_late", {15'd0, late_err}, 16'd1);

      // zero latency clamps to one; invalid request is ignored
      do_reset;
      idle_to(3);
      cas(RD_R, 5'd0, 5'd0, 5'd0, 5'd4);
      chk_cyc("lat0_b0", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      tick;
      chk_cyc("lat0_b1", 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
      tick;
      cas(3'd7, 5'd0, 5'd11, 5'd0, 5'd8);
      chk_all_zero("invalid_req");

      // timestamp wrap: CAS at 250 due at cyc 5 (t=261), reset at cyc 6
      do_reset;
      idle_to(250);
      cas(RD_R, 5'd0, 5'd11, 5'd0, 5'd8);
      while (t <= 262) begin
         inw = t >= 261;
         chk_cyc("wrap", inw, 1'b0, inw ? 2'(t - 261) : 2'd0, 1'b0, 1'b0);
         if (t < 262) tick;
         else break;
      end
      reset = 1'b1;
      tick;
      chk_all_zero("abort_reset");
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk_all_zero("abort_quiet");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
